// File: rtl/pipe_gap_scheduler.sv
// Pipe-gap row scheduler: draws LFSR values, reduces them to legal gap rows and
// queues them in a show-ahead FIFO. Optional GAP_SPREAD_EN limits row change per gap.
module pipe_gap_scheduler #(
  parameter int ROWS      = 16,
  parameter int GAP_H     = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int MAX_STEP  = 3,
  localparam int RW       = $clog2(ROWS),
  localparam int FW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [7:0]    rng_q,
  output logic          rng_incr,
  input  logic          pop,
  output logic [RW-1:0] gap_row,
  output logic          gap_valid,
  output logic [FW-1:0] fill_level
);
  localparam int N  = ROWS - GAP_H - 1;
  localparam int W  = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SAMPLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] retry_q, retry_d;
  logic [W-1:0]  cand;
  logic          push, popv;
  logic [RW-1:0] row_raw, row;
  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic          unused_rng;

  assign cand       = rng_q[W-1:0];
  assign unused_rng = ^rng_q[7:W];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    rng_incr = 1'b0;
    push     = 1'b0;
    row_raw  = '0;
    case (state_q)
      IDLE: if (run && fill_level < FW'(DEPTH)) state_d = REQ;
      REQ: begin
        rng_incr = 1'b1;
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        if (cand < W'(N)) begin
          push    = 1'b1;
          row_raw = RW'(cand) + RW'(1);
        end else if (retry_q < CW'(MAX_RETRY)) begin
          retry_d = retry_q + CW'(1);
          state_d = REQ;
        end else begin
          // out of retries: fold the out-of-range candidate back into range
          push    = 1'b1;
          row_raw = RW'(cand - W'(N)) + RW'(1);
        end
        if (push) begin
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GAP_SPREAD_EN
  localparam int EW = RW + 2;
  logic [RW-1:0] last_q;
  logic [EW-1:0] lo, hi;

  always_comb begin
    lo  = (EW'(last_q) > EW'(MAX_STEP)) ? EW'(last_q) - EW'(MAX_STEP) : EW'(1);
    hi  = (EW'(last_q) + EW'(MAX_STEP) > EW'(N)) ? EW'(N) : EW'(last_q) + EW'(MAX_STEP);
    row = row_raw;
    if (EW'(row_raw) < lo)      row = RW'(lo);
    else if (EW'(row_raw) > hi) row = RW'(hi);
  end

  always_ff @(posedge clk) begin
    if (!reset)    last_q <= RW'((N+1)/2);
    else if (push) last_q <= row;
  end
`else
  assign row = row_raw;
`endif

  assign gap_valid = (fill_level != '0);
  assign gap_row   = gap_valid ? mem[rptr_q] : '0;
  assign popv      = pop && gap_valid;

  always_ff @(posedge clk) begin
    if (reset && push) mem[wptr_q] <= row;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wptr_q <= nxt(wptr_q);
      if (popv) rptr_q <= nxt(rptr_q);
      case ({push, popv})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// Directed bench for pipe_gap_scheduler with a table-driven LFSR stand-in.
module tb_pipe_gap_scheduler;
  logic       clk = 1'b0;
  logic       reset, run, pop;
  logic [7:0] rng_q;
  logic       rng_incr;
  logic [3:0] gap_row;
  logic       gap_valid;
  logic [2:0] fill_level;

  int npass = 0, ntot = 0, incr_cnt = 0, c0;

`ifdef GAP_SPREAD_EN
  localparam int E_FIRST = 3, E_S_HEAD = 4, E_NEW = 5, E_RUN = 8;
`else
  localparam int E_FIRST = 1, E_S_HEAD = 9, E_NEW = 4, E_RUN = 11;
`endif

  // LFSR stand-in: entry 0 is the seed, each advance steps to the next value
  logic [7:0] tbl [0:15] = '{8'h01, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78, 8'hBC, 8'h5E,
                             8'h2F, 8'h17, 8'h03, 8'h0A, 8'h55, 8'h55, 8'h55, 8'h55};
  logic [3:0] idx = '0;
  assign rng_q = tbl[idx];
  always @(posedge clk) begin
    if (!reset)        idx <= '0;
    else if (rng_incr) idx <= idx + 4'd1;
  end

  always #5 clk = ~clk;

  pipe_gap_scheduler dut (
    .clk(clk), .reset(reset), .run(run), .rng_q(rng_q), .rng_incr(rng_incr),
    .pop(pop), .gap_row(gap_row), .gap_valid(gap_valid), .fill_level(fill_level)
  );

  task automatic tick();
    if (rng_incr) incr_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; pop = 1'b0;
    tick(); tick();
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_valid", 32'(gap_valid), 0);
    chk("rst_row", 32'(gap_row), 0);
    chk("rst_incr", 32'(rng_incr), 0);

    // fill from empty
    reset = 1'b1; run = 1'b1;
    tick();
    chk("c1_req", 32'(rng_incr), 1);
    tick();
    chk("c2_rng", 32'(rng_q), 32'h80);
    chk("c2_incr", 32'(rng_incr), 0);
    chk("c2_valid", 32'(gap_valid), 0);
    tick();
    chk("c3_valid", 32'(gap_valid), 1);
    chk("c3_row", 32'(gap_row), E_FIRST);
    chk("c3_fill", 32'(fill_level), 1);
    repeat (8) tick();
    chk("c11_fill", 32'(fill_level), 3);
    tick();
    chk("c12_fill", 32'(fill_level), 4);
    repeat (4) tick();
    chk("full_hold", 32'(fill_level), 4);
    chk("fill_pulses", 32'(incr_cnt), 4);
    chk("full_noincr", 32'(rng_incr), 0);
    chk("full_head", 32'(gap_row), E_FIRST);

    // pop one from full, refill with 0x78
    pop = 1'b1; tick(); pop = 1'b0;
    chk("pop1_fill", 32'(fill_level), 3);
    chk("pop1_head", 32'(gap_row), 1);
    tick();
    chk("refill_req", 32'(rng_incr), 1);
    tick();
    chk("refill_rng", 32'(rng_q), 32'h78);
    chk("refill_pre", 32'(fill_level), 3);
    tick();
    chk("refill_fill", 32'(fill_level), 4);

    // rejection path: BC, 5E rejected, 2F folded
    c0 = incr_cnt;
    pop = 1'b1; tick(); pop = 1'b0;
    repeat (6) tick();
    chk("rej_pre", 32'(fill_level), 3);
    tick();
    chk("rej_fill", 32'(fill_level), 4);
    chk("rej_pulses", 32'(incr_cnt - c0), 3);

    pop = 1'b1; tick(); pop = 1'b0;
    repeat (3) tick();
    chk("p3_fill", 32'(fill_level), 4);
    chk("p3_head", 32'(gap_row), 1);

    // simultaneous push and pop with 3 held
    pop = 1'b1; tick(); pop = 1'b0;
    chk("s_head", 32'(gap_row), E_S_HEAD);
    chk("s_fill", 32'(fill_level), 3);
    tick(); tick();
    chk("s_rng", 32'(rng_q), 32'h03);
    pop = 1'b1; run = 1'b0; tick(); pop = 1'b0;
    chk("pp_fill", 32'(fill_level), 3);
    chk("pp_head", 32'(gap_row), 5);
    tick();
    chk("idle_hold", 32'(rng_incr), 0);
    chk("idle_fill", 32'(fill_level), 3);

    // drain, then pop while empty
    pop = 1'b1;
    tick();
    chk("dr1_head", 32'(gap_row), 8);
    chk("dr1_fill", 32'(fill_level), 2);
    tick();
    chk("dr2_head", 32'(gap_row), E_NEW);
    tick();
    chk("dr3_fill", 32'(fill_level), 0);
    chk("dr3_valid", 32'(gap_valid), 0);
    tick();
    chk("empty_pop_fill", 32'(fill_level), 0);
    chk("empty_pop_row", 32'(gap_row), 0);
    pop = 1'b0;

    // run falls during REQ
    run = 1'b1; tick(); run = 1'b0;
    chk("rf_req", 32'(rng_incr), 1);
    tick(); tick();
    chk("rf_fill", 32'(fill_level), 1);
    chk("rf_row", 32'(gap_row), E_RUN);
    repeat (3) tick();
    chk("rf_hold", 32'(fill_level), 1);
    chk("rf_noincr", 32'(rng_incr), 0);

    // reset while in SAMPLE
    run = 1'b1; tick(); tick();
    reset = 1'b0; run = 1'b0; tick();
    chk("rs_fill", 32'(fill_level), 0);
    chk("rs_valid", 32'(gap_valid), 0);
    chk("rs_row", 32'(gap_row), 0);
    chk("rs_incr", 32'(rng_incr), 0);
    reset = 1'b1; tick();
    chk("rs_nopush", 32'(fill_level), 0);
    chk("rs_idle", 32'(rng_incr), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
